// File: rtl/debug_cmd_rx_if.sv
// Command handshake between the debug UART receiver and the CPU.
// The receiver drives the head frame and valid; the CPU answers with ready.
interface debug_cmd_rx_if;
  logic [7:0]  opcode;
  logic [15:0] data;
  logic        valid;
  logic        ready;

  modport master (output opcode, output data, output valid, input ready);
  modport slave  (input opcode, input data, input valid, output ready);
endinterface

// File: rtl/debug_cmd_rx.sv
// Debug command receiver: 8N1 UART deserialiser, 5-byte frame parser
// (A5, OP, DHI, DLO, CS with CS = OP^DHI^DLO) and a first-word
// fall-through frame FIFO presented on a valid/ready handshake.
//
// RX FSM
//   state    | meaning
//   RX_IDLE  | line idle, waiting for a start bit (armed once line seen high)
//   RX_START | half-bit wait, start bit confirmed or rejected as a glitch
//   RX_DATA  | sampling 8 data bits, LSB first, one per bit period
//   RX_STOP  | sampling the stop bit; strobe the byte or flag a framing error
//
// Parser FSM
//   state    | meaning
//   P_SYNC   | hunting for the 0xA5 sync byte
//   P_OP     | next byte is the opcode
//   P_DHI    | next byte is the data high byte
//   P_DLO    | next byte is the data low byte
//   P_CSUM   | next byte is the checksum; push or drop the frame
module debug_cmd_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_rx,
  debug_cmd_rx_if.master   cmd,
  output logic             o_frame_err,
  output logic             o_csum_err,
  output logic             o_overflow
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0]    SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {P_SYNC, P_OP, P_DHI, P_DLO, P_CSUM} p_state_t;

  logic            rx_meta, rx_sync, rx_arm;
  rx_state_t       rx_state, rx_state_n;
  logic [CW-1:0]   rx_cnt, rx_cnt_n;
  logic [2:0]      rx_bit, rx_bit_n;
  logic [7:0]      rx_shift, rx_shift_n;
  logic            byte_stb, byte_stb_n, frame_err_n;

  p_state_t        p_state, p_state_n;
  logic [7:0]      p_op, p_dhi, p_dlo;
  logic            push_req, csum_bad;

  logic [23:0]     mem [FIFO_DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;
  logic [23:0]     last_head, head;
  logic            empty, full, push, pop;

  // Two-flop synchroniser for the asynchronous line, idle-high reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_sync <= rx_meta;
    end
  end

  // Arm start detection only after the line has been seen idle while enabled,
  // so re-enabling mid-byte waits for the next genuine falling edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        rx_arm <= 1'b0;
    else if (!i_en)   rx_arm <= 1'b0;
    else if (rx_sync) rx_arm <= 1'b1;
  end

  // RX state, bit timer, shifter and byte/framing-error strobes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_state    <= RX_IDLE;
      rx_cnt      <= '0;
      rx_bit      <= '0;
      rx_shift    <= '0;
      byte_stb    <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      rx_state    <= rx_state_n;
      rx_cnt      <= rx_cnt_n;
      rx_bit      <= rx_bit_n;
      rx_shift    <= rx_shift_n;
      byte_stb    <= byte_stb_n;
      o_frame_err <= frame_err_n;
    end
  end

  // RX next-state: down-counter terminal count marks each sample point.
  always_comb begin
    rx_state_n  = rx_state;
    rx_cnt_n    = rx_cnt;
    rx_bit_n    = rx_bit;
    rx_shift_n  = rx_shift;
    byte_stb_n  = 1'b0;
    frame_err_n = 1'b0;
    if (!i_en) begin
      rx_state_n = RX_IDLE;
    end else begin
      unique case (rx_state)
        RX_IDLE: begin
          if (rx_arm && !rx_sync) begin
            rx_state_n = RX_START;
            rx_cnt_n   = HALF_LAST;
          end
        end
        RX_START: begin
          if (rx_cnt == '0) begin
            if (!rx_sync) begin
              rx_state_n = RX_DATA;
              rx_cnt_n   = BIT_LAST;
              rx_bit_n   = '0;
            end else begin
              rx_state_n = RX_IDLE;
            end
          end else begin
            rx_cnt_n = rx_cnt - CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt == '0) begin
            rx_shift_n = {rx_sync, rx_shift[7:1]};
            rx_cnt_n   = BIT_LAST;
            if (rx_bit == 3'd7) rx_state_n = RX_STOP;
            else                rx_bit_n   = rx_bit + 3'd1;
          end else begin
            rx_cnt_n = rx_cnt - CW'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt == '0) begin
            if (rx_sync) byte_stb_n  = 1'b1;
            else         frame_err_n = 1'b1;
            rx_state_n = RX_IDLE;
          end else begin
            rx_cnt_n = rx_cnt - CW'(1);
          end
        end
        default: rx_state_n = RX_IDLE;
      endcase
    end
  end

  // Parser state, captured frame fields and registered error/overflow pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      p_state    <= P_SYNC;
      p_op       <= '0;
      p_dhi      <= '0;
      p_dlo      <= '0;
      o_csum_err <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      p_state    <= p_state_n;
      if (byte_stb && p_state == P_OP)  p_op  <= rx_shift;
      if (byte_stb && p_state == P_DHI) p_dhi <= rx_shift;
      if (byte_stb && p_state == P_DLO) p_dlo <= rx_shift;
      o_csum_err <= csum_bad;
      o_overflow <= push_req && full && !pop;
    end
  end

  // Parser next-state; a framing error or disable drops any partial frame.
  always_comb begin
    p_state_n = p_state;
    push_req  = 1'b0;
    csum_bad  = 1'b0;
    if (!i_en || o_frame_err) begin
      p_state_n = P_SYNC;
    end else if (byte_stb) begin
      unique case (p_state)
        P_SYNC: if (rx_shift == SYNC_BYTE) p_state_n = P_OP;
        P_OP:   p_state_n = P_DHI;
        P_DHI:  p_state_n = P_DLO;
        P_DLO:  p_state_n = P_CSUM;
        P_CSUM: begin
          if (rx_shift == (p_op ^ p_dhi ^ p_dlo)) push_req = 1'b1;
          else                                    csum_bad = 1'b1;
          p_state_n = P_SYNC;
        end
        default: p_state_n = P_SYNC;
      endcase
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && cmd.ready;
  assign push  = push_req && (!full || pop);

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {p_op, p_dhi, p_dlo};
  end

  // FIFO pointers and the last popped frame shown while empty.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      last_head <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + (AW+1)'(1);
        last_head <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

  assign head       = empty ? last_head : mem[rd_ptr[AW-1:0]];
  assign cmd.valid  = !empty;
  assign cmd.opcode = head[23:16];
  assign cmd.data   = head[15:0];

endmodule

// File: tb/tb_debug_cmd_rx.sv
// Directed bench for debug_cmd_rx: frames are serialised at 16 clocks/bit,
// a negedge monitor counts pulses and records popped frames.
module tb_debug_cmd_rx;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst, en, rx;
  logic frame_err, csum_err, overflow;
  int   checks = 0;
  int   failures = 0;

  int          n_ferr = 0, n_cerr = 0, n_ovf = 0, n_valid = 0;
  logic [23:0] popq [$];

  debug_cmd_rx_if cmd ();

  debug_cmd_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_rx(rx), .cmd(cmd),
    .o_frame_err(frame_err), .o_csum_err(csum_err), .o_overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) n_ferr++;
      if (csum_err)  n_cerr++;
      if (overflow)  n_ovf++;
      if (cmd.valid) n_valid++;
      if (cmd.valid && cmd.ready) popq.push_back({cmd.opcode, cmd.data});
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    drive(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(b[i], CPB);
    drive(stop_ok, CPB);
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] hi,
                            input logic [7:0] lo, input logic [7:0] cs);
    send_byte(8'hA5, 1'b1);
    send_byte(op, 1'b1);
    send_byte(hi, 1'b1);
    send_byte(lo, 1'b1);
    send_byte(cs, 1'b1);
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; rx = 1'b1; cmd.ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cmd.valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", cmd.valid); end
    checks++; if (cmd.opcode !== 8'h00) begin failures++; $display("FAIL reset_opcode got=%h exp=00", cmd.opcode); end
    checks++; if (cmd.data !== 16'h0000) begin failures++; $display("FAIL reset_data got=%h exp=0000", cmd.data); end
    checks++; if ({frame_err, csum_err, overflow} !== 3'b000) begin failures++; $display("FAIL reset_pulses got=%b exp=000", {frame_err, csum_err, overflow}); end
    rst = 1'b0;
    drive(1'b1, 2*CPB);
  endtask

  task automatic test_good_frame;
    int p0, v0, f0, c0, o0;
    cmd.ready = 1'b1;
    p0 = popq.size(); v0 = n_valid; f0 = n_ferr; c0 = n_cerr; o0 = n_ovf;
    send_frame(8'h12, 8'h34, 8'h56, 8'h70);
    drive(1'b1, 2*CPB);
    checks++; if (popq.size() - p0 !== 1) begin failures++; $display("FAIL good_pop_count got=%0d exp=1", popq.size() - p0); end
    else begin
      checks++; if (popq[p0] !== 24'h123456) begin failures++; $display("FAIL good_frame got=%h exp=123456", popq[p0]); end
    end
    checks++; if (n_valid - v0 !== 1) begin failures++; $display("FAIL good_valid_cycles got=%0d exp=1", n_valid - v0); end
    checks++; if ((n_ferr - f0) + (n_cerr - c0) + (n_ovf - o0) !== 0) begin failures++; $display("FAIL good_no_errors got=%0d exp=0", (n_ferr - f0) + (n_cerr - c0) + (n_ovf - o0)); end
    checks++; if ({cmd.valid, cmd.opcode, cmd.data} !== 25'h0123456) begin failures++; $display("FAIL good_hold_last got=%h exp=0123456", {cmd.valid, cmd.opcode, cmd.data}); end
  endtask

  task automatic test_csum_err;
    int p0, v0, c0;
    p0 = popq.size(); v0 = n_valid; c0 = n_cerr;
    send_frame(8'h12, 8'h34, 8'h56, 8'h71);
    drive(1'b1, 2*CPB);
    checks++; if (n_cerr - c0 !== 1) begin failures++; $display("FAIL csum_pulse got=%0d exp=1", n_cerr - c0); end
    checks++; if (n_valid - v0 !== 0) begin failures++; $display("FAIL csum_no_valid got=%0d exp=0", n_valid - v0); end
    send_frame(8'hAB, 8'hCD, 8'hEF, 8'h89);
    drive(1'b1, 2*CPB);
    checks++; if (popq.size() - p0 !== 1) begin failures++; $display("FAIL csum_next_count got=%0d exp=1", popq.size() - p0); end
    else begin
      checks++; if (popq[p0] !== 24'hABCDEF) begin failures++; $display("FAIL csum_next_frame got=%h exp=abcdef", popq[p0]); end
    end
  endtask

  task automatic test_garbage;
    int p0, c0, f0;
    p0 = popq.size(); c0 = n_cerr; f0 = n_ferr;
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h5A, 1'b1);
    send_frame(8'h01, 8'h00, 8'h02, 8'h03);
    drive(1'b1, 2*CPB);
    checks++; if (popq.size() - p0 !== 1) begin failures++; $display("FAIL garbage_count got=%0d exp=1", popq.size() - p0); end
    else begin
      checks++; if (popq[p0] !== 24'h010002) begin failures++; $display("FAIL garbage_frame got=%h exp=010002", popq[p0]); end
    end
    checks++; if ((n_cerr - c0) + (n_ferr - f0) !== 0) begin failures++; $display("FAIL garbage_errors got=%0d exp=0", (n_cerr - c0) + (n_ferr - f0)); end
  endtask

  task automatic test_frame_err;
    int p0, f0, c0;
    p0 = popq.size(); f0 = n_ferr; c0 = n_cerr;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b0);
    drive(1'b1, 2*CPB);
    checks++; if (n_ferr - f0 !== 1) begin failures++; $display("FAIL ferr_pulse got=%0d exp=1", n_ferr - f0); end
    send_byte(8'h56, 1'b1);
    send_byte(8'h70, 1'b1);
    send_frame(8'h07, 8'h11, 8'h22, 8'h34);
    drive(1'b1, 2*CPB);
    checks++; if (popq.size() - p0 !== 1) begin failures++; $display("FAIL ferr_resync_count got=%0d exp=1", popq.size() - p0); end
    else begin
      checks++; if (popq[p0] !== 24'h071122) begin failures++; $display("FAIL ferr_resync_frame got=%h exp=071122", popq[p0]); end
    end
    checks++; if (n_cerr - c0 !== 0) begin failures++; $display("FAIL ferr_no_csum got=%0d exp=0", n_cerr - c0); end
  endtask

  task automatic test_back_to_back;
    int p0;
    p0 = popq.size();
    send_frame(8'h0A, 8'hBE, 8'hEF, 8'h5B);
    send_frame(8'h0B, 8'h12, 8'h34, 8'h2D);
    drive(1'b1, 2*CPB);
    checks++; if (popq.size() - p0 !== 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", popq.size() - p0); end
    else begin
      checks++; if ({popq[p0], popq[p0+1]} !== 48'h0ABEEF_0B1234) begin failures++; $display("FAIL b2b_frames got=%h exp=0abeef0b1234", {popq[p0], popq[p0+1]}); end
    end
  endtask

  task automatic test_overflow;
    int o0;
    logic [7:0] op;
    cmd.ready = 1'b0;
    o0 = n_ovf;
    for (int i = 1; i <= 5; i++) begin
      op = 8'(i);
      send_frame(op, {op[3:0], op[3:0]}, {op[3:0], op[3:0]}, op);
    end
    drive(1'b1, 2*CPB);
    checks++; if (n_ovf - o0 !== 1) begin failures++; $display("FAIL ovf_pulse got=%0d exp=1", n_ovf - o0); end
    checks++; if ({cmd.valid, cmd.opcode, cmd.data} !== 25'h1011111) begin failures++; $display("FAIL ovf_head got=%h exp=1011111", {cmd.valid, cmd.opcode, cmd.data}); end
    cmd.ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      op = 8'(i);
      checks++;
      if ({cmd.valid, cmd.opcode, cmd.data} !== {1'b1, op, op[3:0], op[3:0], op[3:0], op[3:0]}) begin
        failures++;
        $display("FAIL ovf_drain_%0d got=%h exp=%h", i, {cmd.valid, cmd.opcode, cmd.data}, {1'b1, op, op[3:0], op[3:0], op[3:0], op[3:0]});
      end
    end
    @(negedge clk);
    checks++; if (cmd.valid !== 1'b0) begin failures++; $display("FAIL ovf_drained_valid got=%b exp=0", cmd.valid); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midop;
    int p0, f0, c0, o0;
    cmd.ready = 1'b0;
    send_frame(8'h61, 8'h00, 8'h05, 8'h64);
    drive(1'b1, 2*CPB);
    checks++; if ({cmd.valid, cmd.opcode} !== 9'h161) begin failures++; $display("FAIL midop_prefill got=%h exp=161", {cmd.valid, cmd.opcode}); end
    f0 = n_ferr; c0 = n_cerr; o0 = n_ovf;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h21, 1'b1);
    send_byte(8'h43, 1'b1);
    drive(1'b0, CPB);
    drive(1'b1, CPB);
    drive(1'b0, 8);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({cmd.valid, cmd.opcode, cmd.data} !== 25'h0) begin failures++; $display("FAIL midop_reset_clear got=%h exp=0000000", {cmd.valid, cmd.opcode, cmd.data}); end
    rst = 1'b0;
    drive(1'b1, 3*CPB);
    cmd.ready = 1'b1;
    p0 = popq.size();
    en = 1'b0;
    send_frame(8'h31, 8'h00, 8'h01, 8'h30);
    drive(1'b1, CPB);
    en = 1'b1;
    drive(1'b1, 2*CPB);
    checks++; if (popq.size() - p0 !== 0) begin failures++; $display("FAIL midop_disabled_pops got=%0d exp=0", popq.size() - p0); end
    send_frame(8'h41, 8'h12, 8'h34, 8'h67);
    drive(1'b1, 2*CPB);
    checks++; if (popq.size() - p0 !== 1) begin failures++; $display("FAIL midop_third_count got=%0d exp=1", popq.size() - p0); end
    else begin
      checks++; if (popq[p0] !== 24'h411234) begin failures++; $display("FAIL midop_third_frame got=%h exp=411234", popq[p0]); end
    end
    checks++; if ((n_ferr - f0) + (n_cerr - c0) + (n_ovf - o0) !== 0) begin failures++; $display("FAIL midop_no_errors got=%0d exp=0", (n_ferr - f0) + (n_cerr - c0) + (n_ovf - o0)); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_csum_err();
    test_garbage();
    test_frame_err();
    test_back_to_back();
    test_overflow();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
